video_pixel_fetch: RTL and testbench
====================================

VIDEO_PIXEL_FETCH -- requirements
Module: video_pixel_fetch

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- PIXEL_BITS, 16, width of one pixel word
- SCREEN_WIDTH, 4, pixels per line
- SCREEN_HEIGHT, 4, lines per frame
- ADDR_BITS, 16, framebuffer address width; SCREEN_WIDTH*SCREEN_HEIGHT SHALL be at most 2^ADDR_BITS
- FIFO_DEPTH, 4, output buffer entries, a power of two and at least 2

REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- in_clk, in, 1, single clock for all logic
- in_rst, in, 1, synchronous, active-low reset
- in_enable, in, 1, allows new framebuffer reads
- out_mem_addr, out, ADDR_BITS, framebuffer read address
- out_mem_rd, out, 1, read strobe
- in_mem_data, in, PIXEL_BITS, read data, valid exactly 1 cycle after out_mem_rd
- out_pixel, out, PIXEL_BITS, pixel to the downstream serial video stage (its in_pixel)
- out_pixel_valid, out, 1, out_pixel holds a valid pixel
- in_pixel_ready, in, 1, downstream accepts the pixel
- out_hpix, out, ceil(log2(SCREEN_WIDTH)), column of the pixel in out_pixel
- out_vpix, out, ceil(log2(SCREEN_HEIGHT)), line of the pixel in out_pixel
- out_frame_start, out, 1, the head pixel is (0,0)
- out_line_end, out, 1, the head pixel is in column SCREEN_WIDTH-1

Function
REQ-003 The read address SHALL start at 0 and advance by 1 for each issued read, in row-major order.
REQ-004 After the read at address SCREEN_WIDTH*SCREEN_HEIGHT-1, the read address SHALL wrap to 0.
REQ-005 The block SHALL assert out_mem_rd in a cycle exactly when in_enable=1 and (FIFO count + in-flight reads) < FIFO_DEPTH, so the FIFO never overflows.
REQ-006 The data of a read issued in cycle N SHALL be written to the FIFO tail at the clock edge ending cycle N+1, together with its column, line, frame-start flag and line-end flag.
REQ-007 out_pixel_valid SHALL be 1 exactly when the FIFO is non-empty.
REQ-008 While out_pixel_valid=1, out_pixel, out_hpix, out_vpix, out_frame_start and out_line_end SHALL describe the FIFO head entry and SHALL hold stable until it is popped.
REQ-009 The head entry SHALL be popped at a clock edge exactly when out_pixel_valid=1 and in_pixel_ready=1.
REQ-010 When a push and a pop occur in the same cycle, the FIFO count SHALL stay unchanged, including when the FIFO is full.
REQ-011 When the FIFO is empty, out_pixel, out_hpix, out_vpix, out_frame_start and out_line_end SHALL be 0.
REQ-012 When in_enable goes to 0, the block SHALL stop issuing reads from the next cycle.
REQ-013 A read already in flight when in_enable goes to 0 SHALL still be captured, and the FIFO SHALL continue to drain normally.
REQ-014 When in_enable returns to 1, reads SHALL resume at the next unread address, with no reset of position and no repeated or skipped pixel.
REQ-015 Latency from reset release with in_enable=1 and in_pixel_ready=1 to the first out_pixel_valid SHALL be 2 cycles.
REQ-016 Steady-state throughput SHALL be 1 pixel per cycle when in_pixel_ready is held at 1.

Reset
REQ-017 While in_rst=0 at a clock edge, the following SHALL be cleared to 0: read address, column/line counters, FIFO count and pointers, and the in-flight flag.
REQ-018 During reset, out_mem_rd, out_mem_addr, out_pixel_valid, out_pixel, out_hpix, out_vpix, out_frame_start and out_line_end SHALL all be 0.
REQ-019 When reset is asserted mid-frame, all buffered and in-flight data SHALL be discarded.
REQ-020 After reset is released, the next frame SHALL start at address 0.

Verification
REQ-021 The bench SHALL cover these directed scenarios with default parameters and mem[a] = 16'h1000 + a:
- Stream test: reset, then in_enable=1 and in_pixel_ready=1 -> first valid pixel 2 cycles after reset release; pixels 16'h1000..16'h100F in order; hpix/vpix run (0,0)..(3,3); out_frame_start=1 only with 16'h1000; out_line_end=1 for 16'h1003, 16'h1007, 16'h100B and 16'h100F.
- Wrap test: continue streaming past 16 pixels -> pixel 17 is 16'h1000 with out_frame_start=1, and no gap in out_pixel_valid.
- Backpressure test: in_pixel_ready=0 for 10 cycles -> exactly 4 entries buffered, out_mem_rd=0 once full, and out_pixel held at 16'h1000; on release, 16'h1000..16'h1003 appear on consecutive cycles with no loss.
- Enable test: in_enable dropped after 5 reads -> 5 pixels delivered, then out_pixel_valid=0; on re-enable, the next pixel is 16'h1005.
- Simultaneous push/pop test: FIFO full with in_pixel_ready=1 -> count stays at 4 and data stays in order.
- Mid-frame reset test: in_rst=0 for 1 cycle after pixel 16'h1006 -> out_pixel_valid=0 during reset; after release, the first pixel is 16'h1000 at (0,0).

Source files
------------

// File: rtl/video_pixel_fetch.sv
// rtl/video_pixel_fetch.sv - row-major framebuffer reader feeding a small pixel FIFO
module video_pixel_fetch #(
    parameter int PIXEL_BITS    = 16,
    parameter int SCREEN_WIDTH  = 4,
    parameter int SCREEN_HEIGHT = 4,
    parameter int ADDR_BITS     = 16,
    parameter int FIFO_DEPTH    = 4,
    localparam int HB = (SCREEN_WIDTH  > 1) ? $clog2(SCREEN_WIDTH)  : 1,
    localparam int VB = (SCREEN_HEIGHT > 1) ? $clog2(SCREEN_HEIGHT) : 1
) (
    input  logic                  in_clk,
    input  logic                  in_rst,
    input  logic                  in_enable,
    output logic [ADDR_BITS-1:0]  out_mem_addr,
    output logic                  out_mem_rd,
    input  logic [PIXEL_BITS-1:0] in_mem_data,
    output logic [PIXEL_BITS-1:0] out_pixel,
    output logic                  out_pixel_valid,
    input  logic                  in_pixel_ready,
    output logic [HB-1:0]         out_hpix,
    output logic [VB-1:0]         out_vpix,
    output logic                  out_frame_start,
    output logic                  out_line_end
);
    localparam int PB   = $clog2(FIFO_DEPTH);
    localparam int CW   = PB + 1;
    localparam int MW   = HB + VB + 2;
    localparam int EW   = PIXEL_BITS + MW;
    localparam int NPIX = SCREEN_WIDTH * SCREEN_HEIGHT;

    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [HB-1:0]        col_q, col_d;
    logic [VB-1:0]        line_q, line_d;
    logic                 fl_q, fl_d;
    logic [MW-1:0]        fl_meta_q, fl_meta_d;
    logic [PB-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic [EW-1:0]        fifo_q [FIFO_DEPTH];
    logic [EW-1:0]        head;
    logic                 rd_issue, push, pop, last_col, last_line;

    assign last_col  = (col_q == HB'(SCREEN_WIDTH - 1));
    assign last_line = (line_q == VB'(SCREEN_HEIGHT - 1));
    // Reserving a slot for the in-flight read keeps the FIFO from ever overflowing.
    assign rd_issue  = in_rst && in_enable && ((int'(count_q) + int'(fl_q)) < FIFO_DEPTH);
    assign push      = fl_q;
    assign pop       = (count_q != '0) && in_pixel_ready;

    always_comb begin
        addr_d    = addr_q;
        col_d     = col_q;
        line_d    = line_q;
        fl_d      = rd_issue;
        fl_meta_d = fl_meta_q;
        wr_ptr_d  = wr_ptr_q + PB'(push);
        rd_ptr_d  = rd_ptr_q + PB'(pop);
        count_d   = count_q + CW'(push) - CW'(pop);
        if (rd_issue) begin
            addr_d    = (addr_q == ADDR_BITS'(NPIX - 1)) ? '0 : addr_q + ADDR_BITS'(1);
            col_d     = last_col ? '0 : col_q + HB'(1);
            if (last_col) begin
                line_d = last_line ? '0 : line_q + VB'(1);
            end
            fl_meta_d = {col_q, line_q, (col_q == '0) && (line_q == '0), last_col};
        end
    end

    always_ff @(posedge in_clk) begin
        if (!in_rst) begin
            addr_q    <= '0;
            col_q     <= '0;
            line_q    <= '0;
            fl_q      <= 1'b0;
            fl_meta_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            addr_q    <= addr_d;
            col_q     <= col_d;
            line_q    <= line_d;
            fl_q      <= fl_d;
            fl_meta_q <= fl_meta_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    // Storage needs no reset: the cleared count masks stale entries.
    always_ff @(posedge in_clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= {in_mem_data, fl_meta_q};
        end
    end

    assign head            = fifo_q[rd_ptr_q];
    assign out_pixel_valid = in_rst && (count_q != '0);
    assign out_mem_rd      = rd_issue;
    assign out_mem_addr    = in_rst ? addr_q : '0;
    assign {out_pixel, out_hpix, out_vpix, out_frame_start, out_line_end} =
        out_pixel_valid ? head : '0;
endmodule

// File: tb/tb_video_pixel_fetch.sv
// tb/tb_video_pixel_fetch.sv - directed, table-driven and randomized checks for video_pixel_fetch
module tb_video_pixel_fetch;
    logic        in_clk = 1'b0;
    logic        in_rst = 1'b0;
    logic        in_enable = 1'b0;
    logic        in_pixel_ready = 1'b0;
    logic [15:0] in_mem_data = 16'h0;
    logic [15:0] out_mem_addr;
    logic        out_mem_rd;
    logic [15:0] out_pixel;
    logic        out_pixel_valid;
    logic [1:0]  out_hpix;
    logic [1:0]  out_vpix;
    logic        out_frame_start;
    logic        out_line_end;

    int n_tests = 0;
    int n_fail  = 0;

    video_pixel_fetch dut (
        .in_clk(in_clk), .in_rst(in_rst), .in_enable(in_enable),
        .out_mem_addr(out_mem_addr), .out_mem_rd(out_mem_rd), .in_mem_data(in_mem_data),
        .out_pixel(out_pixel), .out_pixel_valid(out_pixel_valid), .in_pixel_ready(in_pixel_ready),
        .out_hpix(out_hpix), .out_vpix(out_vpix),
        .out_frame_start(out_frame_start), .out_line_end(out_line_end)
    );

    always #5 in_clk = ~in_clk;

    // Framebuffer: mem[a] = 16'h1000 + a, data one cycle after the strobe.
    always @(posedge in_clk) in_mem_data <= out_mem_rd ? (16'h1000 + out_mem_addr) : 16'hDEAD;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: reads issued (m_r) and pixels popped (m_p) since reset.
    int   m_r = 0;
    int   m_p = 0;
    logic m_prev = 1'b0;

    always @(negedge in_clk) begin
        int   buffered;
        logic exp_rd;
        logic exp_v;
        if (!in_rst) begin
            chk("rst_rd", 32'(out_mem_rd), 0);
            chk("rst_addr", 32'(out_mem_addr), 0);
            chk("rst_valid", 32'(out_pixel_valid), 0);
            chk("rst_pixel", 32'(out_pixel), 0);
            chk("rst_pos", 32'({out_hpix, out_vpix, out_frame_start, out_line_end}), 0);
            m_r = 0;
            m_p = 0;
            m_prev = 1'b0;
        end else begin
            buffered = m_r - int'(m_prev) - m_p;
            exp_v    = (buffered > 0);
            exp_rd   = in_enable && ((m_r - m_p) < 4);
            chk("model_valid", 32'(out_pixel_valid), 32'(exp_v));
            chk("model_rd", 32'(out_mem_rd), 32'(exp_rd));
            if (exp_rd) chk("model_addr", 32'(out_mem_addr), 32'(m_r % 16));
            if (exp_v) begin
                chk("model_pixel", 32'(out_pixel), 32'h1000 + 32'(m_p % 16));
                chk("model_hpix", 32'(out_hpix), 32'(m_p % 4));
                chk("model_vpix", 32'(out_vpix), 32'((m_p % 16) / 4));
                chk("model_fs", 32'(out_frame_start), 32'((m_p % 16) == 0));
                chk("model_le", 32'(out_line_end), 32'((m_p % 4) == 3));
            end else begin
                chk("model_empty_out", 32'({out_pixel, out_hpix, out_vpix, out_frame_start, out_line_end}), 0);
            end
            if (exp_v && in_pixel_ready) m_p++;
            if (exp_rd) m_r++;
            m_prev = exp_rd;
        end
    end

    typedef struct {
        logic        en;
        logic        rdy;
        int          cycles;
        int          exp_reads;
        int          exp_pops;
        logic        exp_valid;
        logic [15:0] exp_pix;
        logic        exp_rd;
    } phase_t;

    phase_t ph[6];

    task automatic next_cycle();
        @(posedge in_clk);
        #1;
    endtask

    task automatic do_reset(input logic en, input logic rdy);
        next_cycle();
        in_rst = 1'b0;
        repeat (2) next_cycle();
        in_rst = 1'b1;
        in_enable = en;
        in_pixel_ready = rdy;
    endtask

    initial begin
        int          reads;
        int          pops;
        logic        found;
        logic        last_v;
        logic        last_rd;
        logic [15:0] last_pix;
        logic [15:0] popq[$];

        ph[0] = '{1'b1, 1'b0, 10, 4, 0, 1'b1, 16'h1000, 1'b0};
        ph[1] = '{1'b0, 1'b1,  6, 0, 4, 1'b0, 16'h0000, 1'b0};
        ph[2] = '{1'b1, 1'b1,  3, 3, 1, 1'b1, 16'h1004, 1'b1};
        ph[3] = '{1'b1, 1'b1,  8, 8, 8, 1'b1, 16'h100C, 1'b1};
        ph[4] = '{1'b0, 1'b0,  5, 0, 0, 1'b1, 16'h100D, 1'b0};
        ph[5] = '{1'b1, 1'b1,  4, 4, 4, 1'b1, 16'h1000, 1'b1};

        // Latency, full-frame stream and wrap into the next frame.
        do_reset(1'b1, 1'b1);
        for (int c = 0; c < 22; c++) begin
            @(negedge in_clk);
            if (c < 2) begin
                chk("lat_valid_low", 32'(out_pixel_valid), 0);
            end else begin
                chk("stream_valid", 32'(out_pixel_valid), 1);
                chk("stream_pixel", 32'(out_pixel), 32'h1000 + 32'((c - 2) % 16));
                chk("stream_fs", 32'(out_frame_start), 32'(((c - 2) % 16) == 0));
                chk("stream_le", 32'(out_line_end), 32'(((c - 2) % 4) == 3));
            end
            next_cycle();
        end

        // Backpressure, drain, enable gating and wrap via the phase table.
        do_reset(1'b1, 1'b0);
        for (int p = 0; p < 6; p++) begin
            in_enable = ph[p].en;
            in_pixel_ready = ph[p].rdy;
            reads = 0;
            pops = 0;
            for (int c = 0; c < ph[p].cycles; c++) begin
                @(negedge in_clk);
                reads += int'(out_mem_rd);
                pops += int'(out_pixel_valid && in_pixel_ready);
                last_v = out_pixel_valid;
                last_pix = out_pixel;
                last_rd = out_mem_rd;
                next_cycle();
            end
            chk($sformatf("ph%0d_reads", p), 32'(reads), 32'(ph[p].exp_reads));
            chk($sformatf("ph%0d_pops", p), 32'(pops), 32'(ph[p].exp_pops));
            chk($sformatf("ph%0d_valid", p), 32'(last_v), 32'(ph[p].exp_valid));
            chk($sformatf("ph%0d_pixel", p), 32'(last_pix), 32'(ph[p].exp_pix));
            chk($sformatf("ph%0d_rd", p), 32'(last_rd), 32'(ph[p].exp_rd));
        end

        // Enable dropped after the fifth read.
        do_reset(1'b1, 1'b1);
        reads = 0;
        popq.delete();
        for (int c = 0; c < 20 && reads < 5; c++) begin
            @(negedge in_clk);
            reads += int'(out_mem_rd);
            if (out_pixel_valid) popq.push_back(out_pixel);
            next_cycle();
        end
        in_enable = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge in_clk);
            chk("en_off_rd", 32'(out_mem_rd), 0);
            if (out_pixel_valid) popq.push_back(out_pixel);
            next_cycle();
        end
        chk("en_reads", 32'(reads), 5);
        chk("en_pops", 32'(popq.size()), 5);
        for (int i = 0; i < popq.size() && i < 5; i++) chk("en_pixel", 32'(popq[i]), 32'h1000 + 32'(i));
        @(negedge in_clk);
        chk("en_drained", 32'(out_pixel_valid), 0);
        next_cycle();
        in_enable = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge in_clk);
            if (out_pixel_valid) begin
                found = 1'b1;
                chk("en_resume_pixel", 32'(out_pixel), 32'h1005);
            end
            next_cycle();
        end
        chk("en_resume_seen", 32'(found), 1);

        // Mid-frame reset right after pixel 0x1006.
        do_reset(1'b1, 1'b1);
        found = 1'b0;
        for (int c = 0; c < 30 && !found; c++) begin
            @(negedge in_clk);
            if (out_pixel_valid && out_pixel == 16'h1006) found = 1'b1;
            next_cycle();
        end
        chk("mid_seen_1006", 32'(found), 1);
        in_rst = 1'b0;
        @(negedge in_clk);
        chk("mid_rst_valid", 32'(out_pixel_valid), 0);
        chk("mid_rst_rd", 32'(out_mem_rd), 0);
        next_cycle();
        in_rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge in_clk);
            if (c < 2) begin
                chk("mid_lat_low", 32'(out_pixel_valid), 0);
            end else begin
                chk("mid_first_valid", 32'(out_pixel_valid), 1);
                chk("mid_first_pixel", 32'(out_pixel), 32'h1000);
                chk("mid_first_pos", 32'({out_hpix, out_vpix}), 0);
                chk("mid_first_fs", 32'(out_frame_start), 1);
            end
            next_cycle();
        end

        // Random enable, ready and occasional reset against the model.
        for (int c = 0; c < 3000; c++) begin
            in_rst = (($urandom % 100) != 0);
            in_enable = (($urandom % 4) != 0);
            in_pixel_ready = (($urandom % 3) != 0);
            next_cycle();
        end
        in_rst = 1'b1;
        next_cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
